// File: rtl/led_scan_mux_pkg.sv
// Shared constants and types for the 4-digit 7-segment scan multiplexer.
// Defaults target the 25 MHz board clock.
package led_scan_mux_pkg;

   localparam int unsigned DIGITS           = 4;
   localparam logic [3:0]  AN_OFF           = 4'b1111;
   localparam int unsigned DEF_CLK_DIV      = 12500;
   localparam int unsigned DEF_BLANK_CYCLES = 64;

   typedef enum logic {
      PhBlank,
      PhShow
   } phase_e;

endpackage

// File: rtl/led_scan_mux.sv
// Scans a frame-snapshotted 16-bit value onto a 4-digit common-anode display,
// one nibble per slot, with a blanking gap at the start of every slot.
module led_scan_mux
   import led_scan_mux_pkg::*;
#(
   parameter int unsigned CLK_DIV      = DEF_CLK_DIV,
   parameter int unsigned BLANK_CYCLES = DEF_BLANK_CYCLES
) (
   input  logic        clk,
   input  logic        reset_in,
   input  logic [15:0] value,
   input  logic [3:0]  dp_in,
   input  logic        lz_blank,
   input  logic        enable,
   output logic [3:0]  hex_digit,
   output logic [3:0]  an_n,
   output logic        dp_n,
   output logic        frame_tick
);

   localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] PCNT_MAX = PW'(CLK_DIV - 1);

   logic [PW-1:0] pcnt;
   logic [1:0]    idx;
   logic [15:0]   snap_value;
   logic [3:0]    snap_dp;
   logic          snap_lz;

   phase_e phase;
   logic   frame_start;
   logic   suppressed;
   logic   lit;

   assign frame_start = (pcnt == '0) && (idx == 2'd0);
   assign phase       = (32'(pcnt) < BLANK_CYCLES) ? PhBlank : PhShow;

   // A digit is dark when it and every more-significant snapshot nibble are zero.
   always_comb begin
      suppressed = snap_lz && (idx != 2'd0);
      for (int i = 1; i < int'(DIGITS); i++) begin
         if (i >= int'(idx) && snap_value[4*i +: 4] != 4'h0) begin
            suppressed = 1'b0;
         end
      end
   end

   assign lit = (phase == PhShow) && enable && !suppressed;

   always_ff @(posedge clk) begin
      if (reset_in) begin
         pcnt       <= '0;
         idx        <= 2'd0;
         snap_value <= 16'h0000;
         snap_dp    <= 4'h0;
         snap_lz    <= 1'b0;
         hex_digit  <= 4'h0;
         an_n       <= AN_OFF;
         dp_n       <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         if (pcnt == PCNT_MAX) begin
            pcnt <= '0;
            idx  <= idx + 2'd1;
         end else begin
            pcnt <= pcnt + PW'(1);
         end

         if (frame_start) begin
            snap_value <= value;
            snap_dp    <= dp_in;
            snap_lz    <= lz_blank;
         end
         frame_tick <= frame_start;

         hex_digit <= snap_value[4*idx +: 4];
         an_n      <= lit ? ~(4'b0001 << idx) : AN_OFF;
         dp_n      <= lit ? ~snap_dp[idx] : 1'b1;
      end
   end

endmodule
